l1_reg_writer: RTL
==================

L1_REG_WRITER -- requirements
Module: l1_reg_writer

Interface
REQ-001 Parameter N_ENTRIES, 56, number of 16-bit entries in the packed layer-1 register.
REQ-002 Parameter WIDTH, 16, bits per entry; total register width = N_ENTRIES*WIDTH = 896.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 l1_store  input  1  random-access write request, sampled each rising edge.
REQ-006 l1_no  input  6  entry index for l1_store, valid range 0..55.
REQ-007 l1_value  input  16  data for l1_store, [15:0] with bit 15 as the MSB.
REQ-008 l1_stored  output  1  one-cycle ack of an accepted l1_store.
REQ-009 l1_err  output  1  one-cycle flag for a rejected l1_store.
REQ-010 fill_start  input  1  starts a sequential fill of entries 0..55.
REQ-011 fill_valid  input  1  fill data valid.
REQ-012 fill_data  input  16  fill data word, [15:0].
REQ-013 fill_ready  output  1  high while the block accepts fill words.
REQ-014 l1_full  output  1  high once all 56 entries have been written by a fill.
REQ-015 l1_reg  output  [0:895]  packed register; entry n occupies bits n*16..n*16+15, value bit 15 at bit n*16.

Function
REQ-016 FSM states: IDLE, FILL, DONE; the reset state is IDLE.
REQ-017 IDLE/DONE, l1_store=1, l1_no<=55, fill_start=0: entry l1_no <= l1_value at the same edge; l1_stored=1 on the next cycle; all other entries unchanged.
REQ-018 l1_store with l1_no in 56..63: no write; l1_err=1 for one cycle; l1_stored=0.
REQ-019 l1_store while in FILL, or in the same cycle as fill_start: rejected, with l1_err=1 for one cycle and no write.
REQ-020 fill_start in any state: go to FILL, fill counter = 0, l1_full = 0; fill_valid in that cycle is ignored; existing l1_reg contents are kept.
REQ-021 FILL: fill_ready=1; each edge with fill_valid=1 writes fill_data to entry counter, then increments counter (6 bits).
REQ-022 FILL, fill_valid=1, counter=55: write entry 55, go to DONE, l1_full=1 from the next cycle; the counter does not wrap.
REQ-023 DONE: fill_ready=0; l1_full stays 1 until the next fill_start or rst; random writes are allowed and do not clear l1_full.
REQ-024 fill_valid outside FILL is ignored.
REQ-025 fill_ready is combinational from state (FILL); l1_stored, l1_err and l1_full are registered.
REQ-026 At most one entry is written per cycle.

Reset
REQ-027 On rst assertion, immediately and regardless of clk: l1_reg=0, state=IDLE, counter=0, l1_stored=0, l1_err=0, l1_full=0, fill_ready=0.
REQ-028 rst asserted mid-fill abandons the fill; after release, the block is in IDLE with every entry zero.
REQ-029 The first edge after rst deassertion processes inputs normally.

Structure
REQ-030 N_ENTRIES, WIDTH, the state encodings (IDLE=0, FILL=1, DONE=2) and the entry bit-offset rule live in a shared l1 package/include file, also used by the fetch-side reader.
REQ-031 The FSM and fill counter are one sub-module, l1_fill_ctrl; the top level holds the packed register and the write mux.

Verification
REQ-032 Scenario: reset, then l1_store with l1_no=0, l1_value=16'hABCD -> l1_reg[0:15]=16'hABCD; l1_stored pulses for 1 cycle; all other bits 0.
REQ-033 Scenario: l1_store with l1_no=55, l1_value=16'h1234 -> l1_reg[880:895]=16'h1234. Then l1_store with l1_no=60 -> l1_err pulses and l1_reg is unchanged.
REQ-034 Scenario: fill_start, then 56 words 16'h0100+n with fill_valid gapped every third cycle -> entry n = 16'h0100+n; l1_full=1; fill_ready=0.
REQ-035 Scenario: l1_store during FILL and l1_store together with fill_start -> l1_err pulses each time and no entry changes; fill_start mid-fill at counter=20 restarts the counter at 0.
REQ-036 Scenario: rst asserted asynchronously (between edges) at counter=30 -> outputs and l1_reg clear immediately; state is IDLE; a subsequent full fill completes normally.
REQ-037 Scenario: write through l1_reg_writer, then read back via the fetch-side reader for indices 0, 27 and 55 -> the values match bit-for-bit.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared layer-1 register definitions: sizes, FSM encodings and the
// entry bit-offset rule, used by the writer and the fetch-side reader.
package l1_pkg;

    localparam int N_ENTRIES = 56;
    localparam int WIDTH     = 16;
    localparam int REG_W     = N_ENTRIES * WIDTH;
    localparam int IDX_W     = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } l1_state_t;

    // Entry n starts at bit n*WIDTH; its value MSB sits at that bit.
    function automatic int entry_off(input int n);
        return n * WIDTH;
    endfunction

    // Fetch-side view of one entry from the packed register.
    function automatic logic [WIDTH-1:0] l1_get(
        input logic [0:REG_W-1] r,
        input int               n
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int b = 0; b < WIDTH; b++) begin
            v[WIDTH-1-b] = r[entry_off(n) + b];
        end
        return v;
    endfunction

endpackage

// File: rtl/l1_reg_writer_fill_ctrl.sv
// Fill FSM, fill counter and store accept/reject handshake.
// Ports: clk, rst (async, active-high); i_l1_store/i_l1_no store request;
//   i_fill_start/i_fill_valid fill control; o_store_we/o_fill_we/o_fill_idx
//   write strobes to the register; fill_ready, l1_full, l1_stored, l1_err.
module l1_fill_ctrl
    import l1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_l1_store,
    input  logic [IDX_W-1:0] i_l1_no,
    input  logic             i_fill_start,
    input  logic             i_fill_valid,
    output logic             o_store_we,
    output logic             o_fill_we,
    output logic [IDX_W-1:0] o_fill_idx,
    output logic             fill_ready,
    output logic             l1_full,
    output logic             l1_stored,
    output logic             l1_err
);

    l1_state_t        r_state;
    l1_state_t        w_next;
    logic [IDX_W-1:0] r_cnt;
    logic             r_full;
    logic             r_stored;
    logic             r_err;
    logic             w_fill_we;
    logic             w_store_ok;
    logic             w_last;

    assign w_last = (r_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // fill_start wins over everything, including a same-cycle fill_valid.
    always_comb begin
        w_next    = r_state;
        w_fill_we = 1'b0;
        if (i_fill_start) begin
            w_next = FILL;
        end else if (r_state == FILL && i_fill_valid) begin
            w_fill_we = 1'b1;
            if (w_last) begin
                w_next = DONE;
            end
        end
    end

    assign w_store_ok = i_l1_store && (i_l1_no <= LAST_IDX)
                        && !i_fill_start && (r_state != FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_stored <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_stored <= w_store_ok;
            r_err    <= i_l1_store && !w_store_ok;
            if (i_fill_start) begin
                r_cnt  <= '0;
                r_full <= 1'b0;
            end else if (w_fill_we) begin
                if (w_last) begin
                    r_full <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_store_we = w_store_ok;
    assign o_fill_we  = w_fill_we;
    assign o_fill_idx = r_cnt;
    assign fill_ready = (r_state == FILL);
    assign l1_full    = r_full;
    assign l1_stored  = r_stored;
    assign l1_err     = r_err;

endmodule

// File: rtl/l1_reg_writer.sv
// Packed layer-1 register with random-access store and sequential fill.
// Ports: clk, rst (async, active-high); l1_store/l1_no/l1_value store
//   request with l1_stored/l1_err acks; fill_start/fill_valid/fill_data
//   fill stream with fill_ready/l1_full; l1_reg packed [0:895] register.
module l1_reg_writer
    import l1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             l1_store,
    input  logic [IDX_W-1:0] l1_no,
    input  logic [WIDTH-1:0] l1_value,
    output logic             l1_stored,
    output logic             l1_err,
    input  logic             fill_start,
    input  logic             fill_valid,
    input  logic [WIDTH-1:0] fill_data,
    output logic             fill_ready,
    output logic             l1_full,
    output logic [0:REG_W-1] l1_reg
);

    logic             w_store_we;
    logic             w_fill_we;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_we;
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_data;
    logic [0:REG_W-1] r_l1_reg;

    l1_fill_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_l1_store   (l1_store),
        .i_l1_no      (l1_no),
        .i_fill_start (fill_start),
        .i_fill_valid (fill_valid),
        .o_store_we   (w_store_we),
        .o_fill_we    (w_fill_we),
        .o_fill_idx   (w_fill_idx),
        .fill_ready   (fill_ready),
        .l1_full      (l1_full),
        .l1_stored    (l1_stored),
        .l1_err       (l1_err)
    );

    // Store and fill strobes are mutually exclusive by state.
    always_comb begin
        w_we   = w_store_we | w_fill_we;
        w_idx  = w_fill_we ? w_fill_idx : l1_no;
        w_data = w_fill_we ? fill_data : l1_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l1_reg <= '0;
        end else if (w_we) begin
            r_l1_reg[entry_off(int'(w_idx)) +: WIDTH] <= w_data;
        end
    end

    assign l1_reg = r_l1_reg;

endmodule
